alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Command-side driver for the 16-bit ALU: accepts one operation per valid/ready handshake,
//  drives stable operands/ALUop into the ALU, waits the op-dependent latency (single-cycle
//  logic/arith ops vs. multi-cycle multiply), captures the 32-bit result and returns it on a
//  valid/ready response port. One op in flight; sits between the control path and the ALU.
// PARAMETERS
//  DATA_W    16  operand width (ALU a/b width)
//  ALU_LAT   1   cycles from issue to result sample for ALUop 0..6 (>=1)
//  MULT_LAT  17  cycles from issue to result sample for ALUop 7 (multiply, >=1)
//  CNT_W     5   latency counter width; must hold max(ALU_LAT,MULT_LAT)-1
// PORTS
//  clk              in   1         rising-edge clock
//  reset            in   1         asynchronous, active-low reset
//  flush            in   1         sync abort of in-flight op, registered response dropped
//  cmd_valid        in   1         command present
//  cmd_ready        out  1         command accepted when cmd_valid&cmd_ready at edge
//  cmd_op           in   3         ALUop: 0 add,1 sub,2 slt,3 and,4 or,5 xor,6 nor,7 mult
//  cmd_a, cmd_b     in   DATA_W    operands
//  alu_a, alu_b     out  DATA_W    operands to ALU (registered)
//  alu_op           out  3         ALUop to ALU (registered)
//  alu_mult_start   out  1         1-cycle pulse starting the sequential multiplier
//  alu_result       in   2*DATA_W  ALU result
//  rsp_valid        out  1         response present
//  rsp_ready        in   1         consumer accepts response
//  rsp_result       out  2*DATA_W  captured result
//  rsp_op           out  3         op that produced rsp_result
//  busy             out  1         state != IDLE
// BEHAVIOUR
//  - Reset (reset=0, async): state IDLE; alu_a/alu_b/alu_op/rsp_result/rsp_op = 0;
//    alu_mult_start, rsp_valid, busy = 0; counter = 0. Takes effect mid-operation, no response.
//  - FSM: IDLE -> EXEC -> RESP -> IDLE.
//    IDLE: cmd_ready=1. On accept (edge E0): latch cmd_a/b/op into alu_a/b/op; counter =
//      (op==7 ? MULT_LAT : ALU_LAT) - 1; go EXEC.
//    EXEC: alu_a/b/op held constant. alu_mult_start=1 only in the first EXEC cycle and only
//      for op 7. Counter decrements each edge; at the edge where counter==0 (edge E0+L),
//      rsp_result<=alu_result, rsp_op<=alu_op, go RESP.
//    RESP: rsp_valid=1, rsp_result/rsp_op stable until rsp_ready. On rsp_ready: if
//      cmd_valid same edge, accept new command directly (-> EXEC), else -> IDLE.
//  - cmd_ready = (state==IDLE) | (state==RESP & rsp_ready); never 1 in EXEC.
//  - Latency: rsp_valid high from edge E0+L, L = ALU_LAT or MULT_LAT; sustained throughput
//    one op per L+1 cycles with rsp_ready=1.
//  - rsp_result passed through unmodified (ALU zero-extends ops 0..6).
//  - flush: in EXEC or RESP -> IDLE at next edge, rsp_valid=0, alu_* hold last values,
//    rsp_result keeps stale value; flush in IDLE ignored; flush wins over same-edge accept
//    and over rsp handshake (no accept that edge).
//  - Inputs cmd_* only sampled at accept; changes afterwards ignored.
// STRUCTURE
//  - Shared package alu_seq_pkg: ALUop localparams (OP_ADD..OP_MULT), FSM state encoding
//    (ST_IDLE, ST_EXEC, ST_RESP), default latencies.
//  - One sub-module: alu_seq_lat_counter (load/decrement/zero-flag, CNT_W wide).
// TESTING
//  1. add a=0x1234 b=0x0101 op=0, rsp_ready=1 -> rsp_valid 1 edge after accept,
//     rsp_result=0x00001335, rsp_op=0, alu_mult_start never 1.
//  2. mult a=0x00FF b=0x0100 op=7 -> alu_mult_start 1 cycle after accept; rsp_valid at
//     E0+17; rsp_result=0x0000FF00; cmd_ready=0 for all 17 EXEC cycles.
//  3. sub a=0x0005 b=0x0007, rsp_ready=0 for 5 cycles -> rsp_valid/rsp_result=0x0000FFFE
//     held, cmd_ready=0; then rsp_ready=1 with cmd_valid=1 -> new cmd accepted same edge.
//  4. mult issued, flush=1 at 8th EXEC cycle -> IDLE next edge, rsp_valid never rises,
//     cmd_ready=1, busy=0.
//  5. reset driven low between edges mid-EXEC -> busy, rsp_valid, alu_* = 0 immediately;
//     after release, add op completes normally.
//  6. back-to-back ops 3,4,5,6 with a=0xF0F0 b=0x0FF0, rsp_ready=1 -> results 0x000000F0,
//     0x0000FFF0, 0x0000FF00, 0x0000000F in order, one per 2 cycles.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU op sequencer: ALUop codes, FSM encoding, default latencies.
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_SLT  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_NOR  = 3'd6;
  localparam logic [2:0] OP_MULT = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_ALU_LAT  = 1;
  localparam int DEF_MULT_LAT = 17;
  localparam int DEF_CNT_W    = 5;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command/response bus between the control path (master) and the sequencer (slave).
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// the sender holds payload stable while valid is high and ready is low.
interface alu_op_sequencer_if #(parameter int DATA_W = 16);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [2:0]          cmd_op;
  logic [DATA_W-1:0]   cmd_a;
  logic [DATA_W-1:0]   cmd_b;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [2*DATA_W-1:0] rsp_result;
  logic [2:0]          rsp_op;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_op
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_op
  );
endinterface

// File: rtl/alu_seq_lat_counter.sv
// Latency down-counter: loads the remaining wait, decrements towards zero, flags zero.
module alu_seq_lat_counter #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/alu_op_sequencer.sv
// Command-side driver for the 16-bit ALU: one op in flight, op-dependent wait,
// result captured and returned on the response side of the bus.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ALU_LAT  = DEF_ALU_LAT,
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  alu_op_sequencer_if.slave   bus,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [2:0]          alu_op,
  output logic                alu_mult_start,
  input  logic [2*DATA_W-1:0] alu_result,
  output logic                busy,
  output state_t              dbg_state
);
  localparam logic [CNT_W-1:0] ALU_LOAD  = CNT_W'(ALU_LAT - 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);

  state_t            state;
  logic              accept;
  logic              cnt_zero;
  logic [CNT_W-1:0]  lat_load;

  // In RESP a flush blocks the direct hand-over to a new command.
  assign bus.cmd_ready = (state == ST_IDLE) ||
                         ((state == ST_RESP) && bus.rsp_ready && !flush);
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign lat_load      = (bus.cmd_op == OP_MULT) ? MULT_LOAD : ALU_LOAD;
  assign bus.rsp_valid = (state == ST_RESP);
  assign busy          = (state != ST_IDLE);
  assign dbg_state     = state;

  alu_seq_lat_counter #(.CNT_W(CNT_W)) u_lat (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (lat_load),
    .dec      ((state == ST_EXEC) && !flush),
    .zero     (cnt_zero)
  );

  // Sequencer FSM: IDLE -> EXEC -> RESP -> IDLE (or RESP -> EXEC on back-to-back accept).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      alu_a          <= '0;
      alu_b          <= '0;
      alu_op         <= '0;
      alu_mult_start <= 1'b0;
      bus.rsp_result <= '0;
      bus.rsp_op     <= '0;
    end else begin
      alu_mult_start <= 1'b0;
      if (accept) begin
        alu_a          <= bus.cmd_a;
        alu_b          <= bus.cmd_b;
        alu_op         <= bus.cmd_op;
        alu_mult_start <= (bus.cmd_op == OP_MULT);
      end
      case (state)
        ST_IDLE: begin
          if (accept) state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (flush) begin
            state <= ST_IDLE;
          end else if (cnt_zero) begin
            bus.rsp_result <= alu_result;
            bus.rsp_op     <= alu_op;
            state          <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (flush)              state <= ST_IDLE;
          else if (accept)        state <= ST_EXEC;
          else if (bus.rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU on the alu_* side.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_op;
  logic        alu_mult_start;
  logic [31:0] alu_result;
  logic        busy;
  state_t      dbg_state;

  int checks;
  int failures;
  logic ever_flag;

  alu_op_sequencer_if #(.DATA_W(16)) bus ();

  alu_op_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .bus            (bus),
    .alu_a          (alu_a),
    .alu_b          (alu_b),
    .alu_op         (alu_op),
    .alu_mult_start (alu_mult_start),
    .alu_result     (alu_result),
    .busy           (busy),
    .dbg_state      (dbg_state)
  );

  // Clock: 10 ns period, rising edge active.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: ops 0..6 zero-extended 16-bit result, op 7 full product.
  logic [15:0] r16;
  always_comb begin
    r16 = '0;
    case (alu_op)
      OP_ADD: r16 = alu_a + alu_b;
      OP_SUB: r16 = alu_a - alu_b;
      OP_SLT: r16 = ($signed(alu_a) < $signed(alu_b)) ? 16'd1 : 16'd0;
      OP_AND: r16 = alu_a & alu_b;
      OP_OR:  r16 = alu_a | alu_b;
      OP_XOR: r16 = alu_a ^ alu_b;
      OP_NOR: r16 = ~(alu_a | alu_b);
      default: r16 = '0;
    endcase
    alu_result = (alu_op == OP_MULT) ? (32'(alu_a) * 32'(alu_b)) : {16'h0000, r16};
  end

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_cmd(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
  endtask

  logic [31:0] exp_res [4];
  logic [2:0]  exp_ops [4];

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    flush = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = '0;
    bus.cmd_a = '0;
    bus.cmd_b = '0;
    bus.rsp_ready = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_rsp_result", bus.rsp_result, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b1;
    tick();

    // 1. add, single-cycle latency
    bus.rsp_ready = 1'b1;
    drive_cmd(OP_ADD, 16'h1234, 16'h0101);
    tick();
    bus.cmd_valid = 1'b0;
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_cmd_ready_exec", 32'(bus.cmd_ready), 32'd0);
    chk("t1_alu_a", 32'(alu_a), 32'h1234);
    chk("t1_mult_start", 32'(alu_mult_start), 32'd0);
    chk("t1_rsp_valid_early", 32'(bus.rsp_valid), 32'd0);
    tick();
    chk("t1_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("t1_rsp_result", bus.rsp_result, 32'h00001335);
    chk("t1_rsp_op", 32'(bus.rsp_op), 32'd0);
    tick();
    chk("t1_idle_after", 32'(busy), 32'd0);

    // 2. mult, 17-cycle latency, cmd changes during EXEC ignored
    drive_cmd(OP_MULT, 16'h00FF, 16'h0100);
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_a = 16'hDEAD;
    chk("t2_mult_start", 32'(alu_mult_start), 32'd1);
    ever_flag = bus.cmd_ready | bus.rsp_valid;
    for (int i = 1; i < 17; i++) begin
      tick();
      if (i == 1) chk("t2_mult_start_pulse", 32'(alu_mult_start), 32'd0);
      ever_flag = ever_flag | bus.cmd_ready | bus.rsp_valid;
    end
    chk("t2_exec_ready_or_valid", 32'(ever_flag), 32'd0);
    chk("t2_alu_a_held", 32'(alu_a), 32'h00FF);
    tick();
    chk("t2_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("t2_rsp_result", bus.rsp_result, 32'h0000FF00);
    chk("t2_rsp_op", 32'(bus.rsp_op), 32'd7);
    tick();

    // 3. sub with back-pressure, then same-edge hand-over
    bus.rsp_ready = 1'b0;
    drive_cmd(OP_SUB, 16'h0005, 16'h0007);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) tick();
    chk("t3_rsp_valid_held", 32'(bus.rsp_valid), 32'd1);
    chk("t3_rsp_result", bus.rsp_result, 32'h0000FFFE);
    chk("t3_cmd_ready_blocked", 32'(bus.cmd_ready), 32'd0);
    bus.rsp_ready = 1'b1;
    drive_cmd(OP_ADD, 16'h0001, 16'h0002);
    #1;
    chk("t3_cmd_ready_handover", 32'(bus.cmd_ready), 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
    chk("t3_new_exec", 32'(dbg_state), 32'(ST_EXEC));
    chk("t3_new_alu_a", 32'(alu_a), 32'h0001);
    tick();
    chk("t3_new_result", bus.rsp_result, 32'h00000003);
    tick();

    // 4. flush in 8th EXEC cycle of a multiply
    drive_cmd(OP_MULT, 16'h0003, 16'h0004);
    tick();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("t4_alu_a_hold", 32'(alu_a), 32'h0003);
    chk("t4_rsp_stale", bus.rsp_result, 32'h00000003);
    ever_flag = bus.rsp_valid;
    for (int i = 0; i < 12; i++) begin
      tick();
      ever_flag = ever_flag | bus.rsp_valid;
    end
    chk("t4_rsp_never", 32'(ever_flag), 32'd0);

    // 5. asynchronous reset mid-EXEC
    drive_cmd(OP_MULT, 16'h0055, 16'h0066);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("t5_alu_ab", {alu_a, alu_b}, 32'd0);
    chk("t5_alu_op", 32'(alu_op), 32'd0);
    #1;
    reset = 1'b1;
    drive_cmd(OP_ADD, 16'h0010, 16'h0020);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    chk("t5_post_valid", 32'(bus.rsp_valid), 32'd1);
    chk("t5_post_result", bus.rsp_result, 32'h00000030);
    tick();

    // 6. back-to-back logic ops, one result every 2 cycles
    exp_res[0] = 32'h000000F0; exp_ops[0] = OP_AND;
    exp_res[1] = 32'h0000FFF0; exp_ops[1] = OP_OR;
    exp_res[2] = 32'h0000FF00; exp_ops[2] = OP_XOR;
    exp_res[3] = 32'h0000000F; exp_ops[3] = OP_NOR;
    drive_cmd(OP_AND, 16'hF0F0, 16'h0FF0);
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k < 3) bus.cmd_op = exp_ops[k+1];
      else bus.cmd_valid = 1'b0;
      tick();
      chk($sformatf("t6_valid_%0d", k), 32'(bus.rsp_valid), 32'd1);
      chk($sformatf("t6_result_%0d", k), bus.rsp_result, exp_res[k]);
      chk($sformatf("t6_op_%0d", k), 32'(bus.rsp_op), 32'(exp_ops[k]));
      tick();
      chk($sformatf("t6_gap_%0d", k), 32'(bus.rsp_valid), 32'd0);
    end
    chk("t6_idle_end", 32'(busy), 32'd0);

    // 7. flush beats same-edge hand-over in RESP; flush ignored in IDLE (slt)
    bus.rsp_ready = 1'b0;
    drive_cmd(OP_SUB, 16'h0009, 16'h0002);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    chk("t7_resp", bus.rsp_result, 32'h00000007);
    bus.rsp_ready = 1'b1;
    flush = 1'b1;
    drive_cmd(OP_SLT, 16'hFFFF, 16'h0001);
    #1;
    chk("t7_ready_flush", 32'(bus.cmd_ready), 32'd0);
    tick();
    chk("t7_flushed_idle", 32'(busy), 32'd0);
    chk("t7_alu_a_hold", 32'(alu_a), 32'h0009);
    tick();
    flush = 1'b0;
    bus.cmd_valid = 1'b0;
    chk("t7_idle_accept", 32'(busy), 32'd1);
    tick();
    chk("t7_slt_result", bus.rsp_result, 32'h00000001);
    chk("t7_slt_op", 32'(bus.rsp_op), 32'd2);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
